// File: rtl/uart_tx.sv
// UART transmitter with a small transmit FIFO.
// 8N1 framing, LSB first, line idles high.
module uart_tx #(
    parameter int BAUDRATE_DIV = 5,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic       o_txp,
    output logic       o_tx_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(BAUDRATE_DIV + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUDRATE_DIV - 1);
    localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_d;
    logic [BW-1:0] baud_cnt, baud_d;
    logic [2:0]    bit_cnt, bit_d;
    logic [7:0]    shreg, shreg_d;
    logic          txp_d;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop, baud_end, fifo_empty;

    assign o_tx_ready = (count != FULL);
    assign fifo_empty = (count == '0);
    assign push       = i_tx_valid && o_tx_ready;
    assign baud_end   = (baud_cnt == BAUD_LAST);
    assign o_tx_busy  = (state != IDLE) || !fifo_empty;

    always_comb begin
        state_d = state;
        baud_d  = baud_cnt + 1'b1;
        bit_d   = bit_cnt;
        shreg_d = shreg;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = mem[rd_ptr];
                    state_d = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shreg_d = shreg >> 1;
                    bit_d   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Chain straight into the next frame when data is waiting.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shreg_d = mem[rd_ptr];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                state_d = IDLE;
            end
        endcase

        unique case (state_d)
            START:   txp_d = 1'b0;
            DATA:    txp_d = shreg_d[0];
            default: txp_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            o_txp    <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state    <= state_d;
            baud_cnt <= baud_d;
            bit_cnt  <= bit_d;
            shreg    <= shreg_d;
            o_txp    <= txp_d;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && rst_n) mem[wr_ptr] <= i_tx_data;
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a line monitor decodes frames into a
// receive queue that is compared against bytes accepted by the handshake.
module tb_uart_tx;

    localparam int DIV = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] i_tx_data;
    logic       i_tx_valid;
    logic       o_tx_ready;
    logic       o_txp;
    logic       o_tx_busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         rx_start_q[$];
    bit         rx_ok_q[$];

    int         mon_phase = -1;
    int         mon_cnt = 0;
    logic [9:0] mon_bits;
    bit         mon_bad;
    int         mon_start;

    uart_tx #(.BAUDRATE_DIV(DIV), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_tx_data (i_tx_data),
        .i_tx_valid(i_tx_valid),
        .o_tx_ready(o_tx_ready),
        .o_txp     (o_txp),
        .o_tx_busy (o_tx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Receiver: checks each bit holds its level for all DIV cycles.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_phase = -1;
        end else if (mon_phase < 0) begin
            if (o_txp === 1'b0) begin
                mon_phase   = 0;
                mon_cnt     = 1;
                mon_bits[0] = 1'b0;
                mon_bad     = 1'b0;
                mon_start   = cyc;
            end
        end else begin
            if (mon_cnt == 0) mon_bits[mon_phase] = o_txp;
            else if (o_txp !== mon_bits[mon_phase]) mon_bad = 1'b1;
            mon_cnt++;
            if (mon_cnt == DIV) begin
                mon_cnt = 0;
                mon_phase++;
                if (mon_phase == 10) begin
                    rx_q.push_back(mon_bits[8:1]);
                    rx_start_q.push_back(mon_start);
                    rx_ok_q.push_back(!mon_bad && mon_bits[9] === 1'b1);
                    mon_phase = -1;
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, output int acc_edge);
        int n = 0;
        i_tx_data  = b;
        i_tx_valid = 1'b1;
        while (o_tx_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (o_tx_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout ready=%b required 1", o_tx_ready);
            acc_edge = -1;
        end else begin
            exp_q.push_back(b);
            @(negedge clk);
            acc_edge = cyc;
        end
        i_tx_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n);
        for (int i = 0; i < 20000 && rx_q.size() < n; i++) @(negedge clk);
        if (rx_q.size() < n) begin
            vectors++;
            miscompares++;
            $display("FAIL rx_timeout got=%0d frames required %0d", rx_q.size(), n);
        end
    endtask

    task automatic drain(input string name);
        logic [7:0] e, r;
        bit ok;
        wait_rx(exp_q.size());
        repeat (2 * DIV) @(negedge clk);
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e  = exp_q.pop_front();
            r  = rx_q.pop_front();
            ok = rx_ok_q.pop_front();
            void'(rx_start_q.pop_front());
            vectors++;
            if (r !== e || !ok) begin
                miscompares++;
                $display("FAIL %s_byte got=%h framing_ok=%0d required %h", name, r, ok, e);
            end
        end
        vectors++;
        if (rx_q.size() != 0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_count extra_rx=%0d missing=%0d required 0",
                     name, rx_q.size(), exp_q.size());
        end
        rx_q.delete();
        rx_start_q.delete();
        rx_ok_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        i_tx_valid = 1'b1;
        i_tx_data  = 8'h77;
        repeat (3) @(negedge clk);
        vectors += 3;
        if (o_txp !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_txp got=%b required 1", o_txp);
        end
        if (o_tx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready got=%b required 1", o_tx_ready);
        end
        if (o_tx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy got=%b required 0", o_tx_busy);
        end
        i_tx_valid = 1'b0;
        rst_n      = 1'b1;
        repeat (15) @(negedge clk);
        vectors++;
        if (o_tx_busy !== 1'b0 || mon_phase >= 0 || rx_q.size() != 0) begin
            miscompares++;
            $display("FAIL reset_no_accept busy=%b frame=%0d required busy 0 no frame",
                     o_tx_busy, mon_phase);
        end
    endtask

    task automatic test_single();
        int e;
        send(8'h55, e);
        while (cyc < e + 50) @(negedge clk);
        vectors++;
        if (o_tx_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_busy_stop got=%b required 1", o_tx_busy);
        end
        @(negedge clk);
        vectors++;
        if (o_tx_busy !== 1'b0 || o_txp !== 1'b1) begin
            miscompares++;
            $display("FAIL single_busy_end busy=%b txp=%b required 0 1", o_tx_busy, o_txp);
        end
        wait_rx(1);
        vectors++;
        if (rx_start_q.size() < 1 || rx_start_q[0] != e + 1) begin
            miscompares++;
            $display("FAIL single_latency start=%0d required %0d",
                     rx_start_q.size() ? rx_start_q[0] : -1, e + 1);
        end
        drain("single");
    endtask

    task automatic test_back_to_back();
        int e1, e2;
        send(8'hA3, e1);
        send(8'h0F, e2);
        vectors++;
        if (e2 != e1 + 1) begin
            miscompares++;
            $display("FAIL b2b_accept edge2=%0d required %0d", e2, e1 + 1);
        end
        wait_rx(2);
        vectors++;
        if (rx_start_q.size() < 2 || rx_start_q[1] - rx_start_q[0] != 10 * DIV) begin
            miscompares++;
            $display("FAIL b2b_gap got=%0d required %0d",
                     rx_start_q.size() >= 2 ? rx_start_q[1] - rx_start_q[0] : -1, 10 * DIV);
        end
        drain("b2b");
    endtask

    task automatic test_fifo_full();
        logic [7:0] nb = 8'h30;
        int first_e = -1;
        int n_acc = 0;
        int n;
        i_tx_valid = 1'b1;
        i_tx_data  = nb;
        for (int i = 0; i < 10; i++) begin
            if (o_tx_ready !== 1'b1) break;
            exp_q.push_back(nb);
            @(negedge clk);
            if (first_e < 0) first_e = cyc;
            n_acc++;
            nb++;
            i_tx_data = nb;
        end
        vectors++;
        if (n_acc != 5 || o_tx_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_accepts got=%0d ready=%b required 5 0", n_acc, o_tx_ready);
        end
        n = 0;
        while (o_tx_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (cyc != first_e + 51) begin
            miscompares++;
            $display("FAIL full_ready_rise cycle=%0d required %0d", cyc, first_e + 51);
        end
        if (o_tx_ready === 1'b1) begin
            exp_q.push_back(nb);
            @(negedge clk);
        end
        i_tx_valid = 1'b0;
        vectors++;
        if (o_tx_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_refill ready=%b required 0", o_tx_ready);
        end
        drain("full");
    endtask

    task automatic test_reset_mid_frame();
        int e, e2, e3, lows = 0;
        send(8'hFF, e);
        send(8'h11, e2);
        send(8'h22, e3);
        while (cyc < e + 1 + 4 * DIV + 1) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (o_txp !== 1'b1 || o_tx_busy !== 1'b0 || o_tx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_outputs txp=%b busy=%b ready=%b required 1 0 1",
                     o_txp, o_tx_busy, o_tx_ready);
        end
        rst_n = 1'b1;
        exp_q.delete();
        repeat (120) begin
            @(negedge clk);
            if (o_txp !== 1'b1) lows++;
        end
        vectors++;
        if (lows != 0 || rx_q.size() != 0 || o_tx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_quiet low_cycles=%0d frames=%0d busy=%b required 0 0 0",
                     lows, rx_q.size(), o_tx_busy);
        end
        rx_q.delete();
        rx_start_q.delete();
        rx_ok_q.delete();
    endtask

    task automatic test_loopback();
        int e;
        for (int i = 0; i < 16; i++) begin
            send(8'($urandom_range(0, 255)), e);
            repeat ($urandom_range(0, 60)) @(negedge clk);
        end
        drain("loopback");
    endtask

    initial begin
        rst_n      = 1'b0;
        i_tx_valid = 1'b0;
        i_tx_data  = 8'h00;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_fifo_full();
        test_reset_mid_frame();
        test_loopback();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
